reg4_sequencer: RTL and testbench

- Command-driven controller for the 4-bit multifunction register (clear/load/inc/dec/shift-right/shift-left with serial inputs).
- Accepts one command at a time over a valid/ready handshake and drives the register's one-hot control strobes for 1..2^CNT_W consecutive cycles.
- Rotates are built by feeding the register's own edge bits back into its serial inputs.
- Reports completion with a one-cycle done pulse.

---
 rtl/reg4_seq_pkg.sv | 30 +++
 rtl/reg4_strobe_dec.sv | 63 ++++++
 rtl/reg4_sequencer.sv | 143 ++++++++++++++
 tb/tb_reg4_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg4_seq_pkg.sv
// Shared types and defaults for the 4-bit register sequencer.
// Used by reg4_sequencer and reg4_strobe_dec.
package reg4_seq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    OP_CLR  = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_ROL  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // CLR and LOAD are single-shot; their repeat field is ignored.
  function automatic logic op_uses_cnt(input op_t op);
    return !(op == OP_CLR || op == OP_LOAD);
  endfunction

endpackage

// File: rtl/reg4_strobe_dec.sv
// Combinational decode of the latched opcode into the register's one-hot
// control strobes, serial fill bits and parallel load data.
module reg4_strobe_dec
  import reg4_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              exec,
  input  logic              fire,
  input  op_t               op,
  input  logic [DATA_W-1:0] data,
  input  logic              q_lsb,
  input  logic              q_msb,
  output logic              reg_cl,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_sr,
  output logic              reg_sl,
  output logic              reg_ir,
  output logic              reg_il,
  output logic [DATA_W-1:0] reg_in
);

  always_comb begin
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_sl  = 1'b0;
    reg_ir  = 1'b0;
    reg_il  = 1'b0;
    if (fire) begin
      case (op)
        OP_CLR:  reg_cl  = 1'b1;
        OP_LOAD: reg_ld  = 1'b1;
        OP_INC:  reg_inc = 1'b1;
        OP_DEC:  reg_dec = 1'b1;
        OP_SHR:  reg_sr  = 1'b1;
        OP_SHL:  reg_sl  = 1'b1;
        // Rotates recirculate the bit that falls off the opposite edge.
        OP_ROR: begin
          reg_sr = 1'b1;
          reg_ir = q_lsb;
        end
        OP_ROL: begin
          reg_sl = 1'b1;
          reg_il = q_msb;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_in
      assign reg_in[gi] = exec & data[gi];
    end
  endgenerate

endmodule

// File: rtl/reg4_sequencer.sv
// Command-driven sequencer for the 4-bit multifunction register.
// Optional INC/DEC saturation stop is enabled by defining REG4_SEQ_SATURATE_EN.
module reg4_sequencer
  import reg4_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              abort,
  input  logic [DATA_W-1:0] reg_q,
  output logic              reg_cl,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_sr,
  output logic              reg_sl,
  output logic              reg_ir,
  output logic              reg_il,
  output logic [DATA_W-1:0] reg_in,
  output logic              busy,
  output logic              done,
`ifdef REG4_SEQ_SATURATE_EN
  output logic              sat,
`endif
  output logic              aborted
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   remain_reg, remain_next;
  op_t                op_reg, op_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               aborted_reg, aborted_next;
  logic               sat_stop;

`ifdef REG4_SEQ_SATURATE_EN
  logic sat_reg, sat_next;

  assign sat_stop = (state_reg == S_EXEC) &&
                    (((op_reg == OP_INC) && (&reg_q)) ||
                     ((op_reg == OP_DEC) && !(|reg_q)));
  assign sat      = (state_reg == S_DONE) & sat_reg;
`else
  // Only the edge bits of reg_q matter without the saturation check.
  logic unused_q;
  assign unused_q = ^reg_q;
  assign sat_stop = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    remain_next  = remain_reg;
    op_next      = op_reg;
    data_next    = data_reg;
    aborted_next = aborted_reg;
`ifdef REG4_SEQ_SATURATE_EN
    sat_next     = sat_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next   = S_EXEC;
          op_next      = op_t'(cmd_op);
          data_next    = cmd_data;
          remain_next  = op_uses_cnt(op_t'(cmd_op)) ? cmd_cnt : '0;
          aborted_next = 1'b0;
`ifdef REG4_SEQ_SATURATE_EN
          sat_next     = 1'b0;
`endif
        end
      end
      S_EXEC: begin
        if (sat_stop) begin
          state_next   = S_DONE;
          aborted_next = 1'b0;
`ifdef REG4_SEQ_SATURATE_EN
          sat_next     = 1'b1;
`endif
        end else if (remain_reg == '0 || abort) begin
          state_next   = S_DONE;
          // An abort landing on the final strobe finishes normally.
          aborted_next = abort && (remain_reg != '0);
        end else begin
          remain_next = remain_reg - CNT_W'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      remain_reg  <= '0;
      op_reg      <= OP_CLR;
      data_reg    <= '0;
      aborted_reg <= 1'b0;
`ifdef REG4_SEQ_SATURATE_EN
      sat_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      remain_reg  <= remain_next;
      op_reg      <= op_next;
      data_reg    <= data_next;
      aborted_reg <= aborted_next;
`ifdef REG4_SEQ_SATURATE_EN
      sat_reg     <= sat_next;
`endif
    end
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign aborted   = done & aborted_reg;

  reg4_strobe_dec #(.DATA_W(DATA_W)) u_dec (
    .exec    (state_reg == S_EXEC),
    .fire    ((state_reg == S_EXEC) && !sat_stop),
    .op      (op_reg),
    .data    (data_reg),
    .q_lsb   (reg_q[0]),
    .q_msb   (reg_q[DATA_W-1]),
    .reg_cl  (reg_cl),
    .reg_ld  (reg_ld),
    .reg_inc (reg_inc),
    .reg_dec (reg_dec),
    .reg_sr  (reg_sr),
    .reg_sl  (reg_sl),
    .reg_ir  (reg_ir),
    .reg_il  (reg_il),
    .reg_in  (reg_in)
  );

endmodule

// File: tb/tb_reg4_sequencer.sv
// Directed bench for reg4_sequencer; models the controlled 4-bit register
// locally and checks strobes, latency, abort and reset behaviour.
module tb_reg4_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] cmd_cnt = 4'd0;
  logic       abort = 1'b0;
  logic [3:0] q_model = 4'd0;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
  logic [3:0] reg_in;
  logic       busy, done, aborted;
  logic [5:0] stb;
  int         n_vec = 0;
  int         n_err = 0;

`ifdef REG4_SEQ_SATURATE_EN
  logic sat;
  logic exp_sat = 1'b0;
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  reg4_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .abort(abort),
    .reg_q(q_model), .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc),
    .reg_dec(reg_dec), .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir),
    .reg_il(reg_il), .reg_in(reg_in), .busy(busy), .done(done),
`ifdef REG4_SEQ_SATURATE_EN
    .sat(sat),
`endif
    .aborted(aborted)
  );

  assign stb = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};

  // The register being controlled.
  always @(posedge clk) begin
    if (reg_cl)       q_model <= 4'd0;
    else if (reg_ld)  q_model <= reg_in;
    else if (reg_inc) q_model <= q_model + 4'd1;
    else if (reg_dec) q_model <= q_model - 4'd1;
    else if (reg_sr)  q_model <= {reg_ir, q_model[3:1]};
    else if (reg_sl)  q_model <= {q_model[2:0], reg_il};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt,
                         input int abort_at, input int exp_n, input int exp_lat,
                         input logic exp_ab, input logic [3:0] exp_q);
    int  n = 0;
    int  k;
    bit  seen = 1'b0;
    @(negedge clk);
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt;
    for (k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("latency", k, exp_lat);
        chk("aborted", aborted, exp_ab);
`ifdef REG4_SEQ_SATURATE_EN
        chk("sat", sat, exp_sat);
`endif
      end else if (!(SAT_BUILD && stb == 6'd0)) begin
        chk("one_hot", $countones(stb), 1);
        chk("reg_in", reg_in, data);
        if (op == 3'd6)      chk("ror_ir", {reg_ir, reg_il}, {q_model[0], 1'b0});
        else if (op == 3'd7) chk("rol_il", {reg_ir, reg_il}, {1'b0, q_model[3]});
        else                 chk("fill_zero", {reg_ir, reg_il}, 2'b00);
        n++;
        if (n == abort_at) abort = 1'b1;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("strobe_count", n, exp_n);
    chk("reg_q", q_model, exp_q);
    @(negedge clk);
    chk("ready_after", cmd_ready, 1);
    $display("cmd op=%0d data=%h cnt=%0d: strobes=%0d q=%h", op, data, cnt, n, q_model);
  endtask

  logic [3:0] ror_exp [4];

  initial begin
    ror_exp[0] = 4'b1001; ror_exp[1] = 4'b1100;
    ror_exp[2] = 4'b0110; ror_exp[3] = 4'b0011;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {stb, reg_ir, reg_il, reg_in, busy, done, aborted}, 0);
    $display("reset: ready=%0d busy=%0d", cmd_ready, busy);

    // LOAD ignores its count field.
    run_cmd(3'd1, 4'hA, 4'd5, 0, 1, 2, 1'b0, 4'hA);
    run_cmd(3'd0, 4'h0, 4'd9, 0, 1, 2, 1'b0, 4'h0);

    run_cmd(3'd1, 4'hE, 4'd0, 0, 1, 2, 1'b0, 4'hE);
`ifdef REG4_SEQ_SATURATE_EN
    exp_sat = 1'b1;
    run_cmd(3'd2, 4'h0, 4'd3, 0, 1, 3, 1'b0, 4'hF);
    exp_sat = 1'b0;
`else
    run_cmd(3'd2, 4'h0, 4'd3, 0, 4, 5, 1'b0, 4'h2);
`endif

    for (int c = 0; c < 4; c++) begin
      run_cmd(3'd1, 4'b0011, 4'd0, 0, 1, 2, 1'b0, 4'b0011);
      run_cmd(3'd6, 4'h0, c[3:0], 0, c + 1, c + 2, 1'b0, ror_exp[c]);
    end

    run_cmd(3'd1, 4'b1011, 4'd0, 0, 1, 2, 1'b0, 4'b1011);
    run_cmd(3'd5, 4'h0, 4'd1, 0, 2, 3, 1'b0, 4'b1100);
    run_cmd(3'd1, 4'b1000, 4'd0, 0, 1, 2, 1'b0, 4'b1000);
    run_cmd(3'd7, 4'h0, 4'd0, 0, 1, 2, 1'b0, 4'b0001);

    // Abort on the final strobe is a normal completion.
    run_cmd(3'd1, 4'b1100, 4'd0, 0, 1, 2, 1'b0, 4'b1100);
    run_cmd(3'd4, 4'h0, 4'd1, 2, 2, 3, 1'b0, 4'b0011);

    run_cmd(3'd1, 4'h8, 4'd0, 0, 1, 2, 1'b0, 4'h8);
    run_cmd(3'd3, 4'h0, 4'd15, 3, 3, 4, 1'b1, 4'h5);

    // Reset in the middle of an INC run.
    run_cmd(3'd1, 4'h0, 4'd0, 0, 1, 2, 1'b0, 4'h0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_cnt = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_inc1", reg_inc, 1);
    @(negedge clk);
    chk("mid_inc2", reg_inc, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_strobes", stb, 0);
    chk("rst_busy_done", {busy, done}, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst", {cmd_ready, done, stb}, 8'h80);
    end
    chk("rst_q", q_model, 4'h2);
    $display("reset mid-exec: q=%h ready=%0d", q_model, cmd_ready);

    // cmd_valid held while busy is only taken once the controller is idle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'h5; cmd_cnt = 4'd0;
    @(negedge clk);
    cmd_op = 3'd2; cmd_data = 4'h0;
    chk("held_ld", {reg_ld, cmd_ready}, 2'b10);
    @(negedge clk);
    chk("held_done", {done, reg_inc}, 2'b10);
    @(negedge clk);
    chk("held_idle", {cmd_ready, reg_inc}, 2'b10);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_inc", reg_inc, 1);
    @(negedge clk);
    chk("held_done2", done, 1);
    @(negedge clk);
    chk("held_q", q_model, 4'h6);
    $display("held valid: q=%h", q_model);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
